// File: rtl/audio_out_stage.sv
// Final audio conditioning stage: optional DC blocker, click-free soft mute/unmute
// gain ramp and signed-to-offset-binary conversion for the sigma-delta DAC.
module audio_out_stage #(
    parameter int HOLD_TICKS = 8388608,
    parameter int RAMP_DIV   = 256,
    parameter int DC_EN      = 1,
    parameter int DC_SHIFT   = 10
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce,
    input  logic        mute,
    input  logic [15:0] in_l,
    input  logic [15:0] in_r,
    output logic [15:0] out_l,
    output logic [15:0] out_r,
    output logic        out_valid,
    output logic        muted,
    output logic [1:0]  dbg_state,
    output logic [8:0]  dbg_gain
);

    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam int RW = $clog2(RAMP_DIV + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_DIV - 1);

    typedef enum logic [1:0] {
        ST_MUTED     = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_UNMUTED   = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [8:0]      gain, gain_nxt;
    logic [HW-1:0]   hold_cnt, hold_nxt;
    logic [RW-1:0]   ramp_cnt, ramp_nxt;
    logic            ramp_wrap;

    logic signed [15:0] x_l, x_r, xp_l, xp_r, d1_l, d1_r;
    logic signed [17:0] yp_l, yp_r, y_l, y_r;
    logic signed [23:0] p_l, p_r;
    logic [15:0]        s_l, s_r;

    function automatic logic signed [17:0] dc_filter(input logic signed [15:0] x,
                                                     input logic signed [15:0] xp,
                                                     input logic signed [17:0] yp);
        logic signed [17:0] xe;
        logic signed [17:0] xpe;
        xe  = {{2{x[15]}}, x};
        xpe = {{2{xp[15]}}, xp};
        return xe - xpe + yp - (yp >>> DC_SHIFT);
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [17:0] y);
        if (y > 18'sd32767)       return 16'sh7FFF;
        else if (y < -18'sd32768) return 16'sh8000;
        else                      return y[15:0];
    endfunction

    // out_valid is a one-cycle strobe with no backpressure: out_l/out_r are
    // stable from that cycle until the next ce edge.
    assign muted     = (state == ST_MUTED) || (state == ST_RAMP_UP);
    assign dbg_state = state;
    assign dbg_gain  = gain;
    assign ramp_wrap = (ramp_cnt == RAMP_LAST);

    always_comb begin
        state_nxt = state;
        gain_nxt  = gain;
        hold_nxt  = hold_cnt;
        ramp_nxt  = ramp_cnt;
        case (state)
            ST_MUTED: begin
                gain_nxt = 9'd0;
                if (mute) begin
                    hold_nxt = '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt = ST_RAMP_UP;
                    hold_nxt  = '0;
                    ramp_nxt  = '0;
                end else begin
                    hold_nxt = hold_cnt + HW'(1);
                end
            end
            ST_RAMP_UP: begin
                // A mute edge wins over a coincident ramp wrap: no gain step.
                if (mute) begin
                    state_nxt = ST_RAMP_DOWN;
                    ramp_nxt  = '0;
                end else if (ramp_wrap) begin
                    ramp_nxt = '0;
                    if (gain >= 9'd255) begin
                        gain_nxt  = 9'd256;
                        state_nxt = ST_UNMUTED;
                    end else begin
                        gain_nxt = gain + 9'd1;
                    end
                end else begin
                    ramp_nxt = ramp_cnt + RW'(1);
                end
            end
            ST_UNMUTED: begin
                if (mute) begin
                    state_nxt = ST_RAMP_DOWN;
                    ramp_nxt  = '0;
                end
            end
            ST_RAMP_DOWN: begin
                if (!mute) begin
                    state_nxt = ST_RAMP_UP;
                    ramp_nxt  = '0;
                end else if (ramp_wrap) begin
                    ramp_nxt = '0;
                    if (gain <= 9'd1) begin
                        gain_nxt  = 9'd0;
                        state_nxt = ST_MUTED;
                        hold_nxt  = '0;
                    end else begin
                        gain_nxt = gain - 9'd1;
                    end
                end else begin
                    ramp_nxt = ramp_cnt + RW'(1);
                end
            end
            default: begin
                state_nxt = ST_MUTED;
                gain_nxt  = 9'd0;
                hold_nxt  = '0;
                ramp_nxt  = '0;
            end
        endcase
    end

    assign x_l = in_l;
    assign x_r = in_r;
    assign y_l = dc_filter(x_l, xp_l, yp_l);
    assign y_r = dc_filter(x_r, xp_r, yp_r);

    // Multiply uses the registered gain, so a gain step lands on the next sample.
    assign p_l = 24'(d1_l) * 24'($signed({1'b0, gain}));
    assign p_r = 24'(d1_r) * 24'($signed({1'b0, gain}));
    assign s_l = 16'(p_l >>> 8);
    assign s_r = 16'(p_r >>> 8);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= ST_MUTED;
            gain      <= 9'd0;
            hold_cnt  <= '0;
            ramp_cnt  <= '0;
            xp_l      <= '0;
            xp_r      <= '0;
            yp_l      <= '0;
            yp_r      <= '0;
            d1_l      <= '0;
            d1_r      <= '0;
            out_l     <= 16'h8000;
            out_r     <= 16'h8000;
            out_valid <= 1'b0;
        end else begin
            out_valid <= ce;
            if (ce) begin
                state    <= state_nxt;
                gain     <= gain_nxt;
                hold_cnt <= hold_nxt;
                ramp_cnt <= ramp_nxt;
                xp_l     <= x_l;
                xp_r     <= x_r;
                yp_l     <= y_l;
                yp_r     <= y_r;
                d1_l     <= (DC_EN != 0) ? sat16(y_l) : x_l;
                d1_r     <= (DC_EN != 0) ? sat16(y_r) : x_r;
                out_l    <= {~s_l[15], s_l[14:0]};
                out_r    <= {~s_r[15], s_r[14:0]};
            end
        end
    end

endmodule

// File: tb/tb_audio_out_stage.sv
// Bench for audio_out_stage: a bypass instance and a DC-blocking instance share
// stimulus; a reference model feeds per-instance expected queues.
module tb_audio_out_stage;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        ce      = 1'b0;
    logic        mute    = 1'b0;
    logic [15:0] in_l    = 16'h0000;
    logic [15:0] in_r    = 16'h0000;

    logic [15:0] out_l_a, out_r_a, out_l_b, out_r_b;
    logic        valid_a, valid_b, muted_a, muted_b;
    logic [1:0]  state_a, state_b;
    logic [8:0]  gain_a, gain_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q_a[$];
    logic [31:0] exp_q_b[$];
    logic [31:0] last_exp_a;

    // reference model state (RAMP_DIV=1: every ramp tick is a wrap)
    int m_state, m_hold, m_gain;
    int m_d1[2][2];
    int m_xp[2][2];
    int m_yp[2][2];

    audio_out_stage #(.HOLD_TICKS(4), .RAMP_DIV(1), .DC_EN(0), .DC_SHIFT(4)) u_byp (
        .clk_sys(clk_sys), .reset(reset), .ce(ce), .mute(mute),
        .in_l(in_l), .in_r(in_r), .out_l(out_l_a), .out_r(out_r_a),
        .out_valid(valid_a), .muted(muted_a), .dbg_state(state_a), .dbg_gain(gain_a)
    );

    audio_out_stage #(.HOLD_TICKS(4), .RAMP_DIV(1), .DC_EN(1), .DC_SHIFT(4)) u_dc (
        .clk_sys(clk_sys), .reset(reset), .ce(ce), .mute(mute),
        .in_l(in_l), .in_r(in_r), .out_l(out_l_b), .out_r(out_r_b),
        .out_valid(valid_b), .muted(muted_b), .dbg_state(state_b), .dbg_gain(gain_b)
    );

    // clock / watchdog
    always #5 clk_sys = ~clk_sys;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // model
    function automatic int to_int16(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    task automatic model_reset();
        m_state = 0; m_hold = 0; m_gain = 0;
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < 2; c++) begin
                m_d1[i][c] = 0; m_xp[i][c] = 0; m_yp[i][c] = 0;
            end
    endtask

    task automatic model_tick(input logic m, input logic [15:0] l, input logic [15:0] r);
        int x[2];
        int y;
        logic [15:0] eo[2];
        x[0] = to_int16(l);
        x[1] = to_int16(r);
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 2; c++) begin
                eo[c] = 16'(((m_d1[i][c] * m_gain) >>> 8) + 32768);
                if (i == 1) begin
                    y = x[c] - m_xp[i][c] + m_yp[i][c] - (m_yp[i][c] >>> 4);
                    y = y & 32'h3FFFF;
                    if (y >= 32'h20000) y = y - 32'h40000;
                    m_xp[i][c] = x[c];
                    m_yp[i][c] = y;
                    m_d1[i][c] = (y > 32767) ? 32767 : ((y < -32768) ? -32768 : y);
                end else begin
                    m_d1[i][c] = x[c];
                end
            end
            if (i == 0) begin
                exp_q_a.push_back({eo[0], eo[1]});
                last_exp_a = {eo[0], eo[1]};
            end else begin
                exp_q_b.push_back({eo[0], eo[1]});
            end
        end
        case (m_state)
            0: if (m) m_hold = 0;
               else if (m_hold == 3) begin m_state = 1; m_hold = 0; end
               else m_hold++;
            1: if (m) m_state = 3;
               else begin m_gain++; if (m_gain == 256) m_state = 2; end
            2: if (m) m_state = 3;
            default: if (!m) m_state = 1;
               else begin
                   if (m_gain > 0) m_gain--;
                   if (m_gain == 0) begin m_state = 0; m_hold = 0; end
               end
        endcase
    endtask

    // driver tasks
    task automatic drive(input logic m, input logic [15:0] l, input logic [15:0] r);
        @(negedge clk_sys);
        ce = 1'b1; mute = m; in_l = l; in_r = r;
        model_tick(m, l, r);
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk_sys);
        ce = 1'b0;
        @(negedge clk_sys);
        check_eq("q_drain", 32'(exp_q_a.size() + exp_q_b.size()), 32'd0);
        reset = 1'b1; in_l = 16'h4000; in_r = 16'h4000; mute = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_sys);
            ce = ~ce;
            check_eq("rst_out", {out_l_a, out_r_b}, 32'h8000_8000);
            check_eq("rst_muted", {31'd0, muted_a & muted_b}, 32'd1);
            check_eq("rst_valid", {31'd0, valid_a | valid_b}, 32'd0);
        end
        @(negedge clk_sys);
        reset = 1'b0; ce = 1'b0;
        model_reset();
        check_eq("rst_gain", {23'd0, gain_a}, 32'd0);
        check_eq("rst_state", {30'd0, state_a}, 32'd0);
    endtask

    // scoreboard
    always @(negedge clk_sys) begin
        if (!reset) begin
            if (valid_a) begin
                if (exp_q_a.size() == 0) check_eq("sb_a_empty", 32'd1, 32'd0);
                else check_eq("sb_a", {out_l_a, out_r_a}, exp_q_a.pop_front());
            end
            if (valid_b) begin
                if (exp_q_b.size() == 0) check_eq("sb_b_empty", 32'd1, 32'd0);
                else check_eq("sb_b", {out_l_b, out_r_b}, exp_q_b.pop_front());
            end
        end
    end

    initial begin
        model_reset();
        last_exp_a = 32'h8000_8000;
        do_reset(6);

        // unmute ramp
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 16'h4000, 16'h4000);
            check_eq("hold_out", {out_l_a, out_r_a}, 32'h8000_8000);
            check_eq("hold_muted", {31'd0, muted_a}, 32'd1);
            if (k == 2) check_eq("hold_state", {30'd0, state_a}, 32'd0);
        end
        check_eq("hold_done", {30'd0, state_a}, 32'd1);
        for (int k = 1; k <= 256; k++) begin
            drive(1'b0, 16'h4000, 16'h4000);
            if (k == 1 || k == 129 || k == 200) check_eq("ramp_gain", {23'd0, gain_a}, 32'(k));
            if (k == 129) check_eq("ramp_half", {16'd0, out_l_a}, 32'h0000_A000);
        end
        check_eq("unmuted_state", {30'd0, state_a}, 32'd2);
        check_eq("unmuted_flag", {31'd0, muted_a}, 32'd0);
        drive(1'b0, 16'h4000, 16'h4000);
        check_eq("unity_out", {out_l_a, out_r_a}, 32'hC000_C000);

        // extremes with latency
        drive(1'b0, 16'h8000, 16'h8000);
        drive(1'b0, 16'h8000, 16'h8000);
        check_eq("ext_neg", {out_l_a, out_r_a}, 32'h0000_0000);
        drive(1'b0, 16'h7FFF, 16'h7FFF);
        check_eq("ext_latency", {16'd0, out_l_a}, 32'h0000_0000);
        drive(1'b0, 16'h7FFF, 16'h7FFF);
        check_eq("ext_pos", {out_l_a, out_r_a}, 32'hFFFF_FFFF);
        drive(1'b0, 16'hFFFF, 16'hFFFF);
        drive(1'b0, 16'hFFFF, 16'hFFFF);
        check_eq("ext_m1", {out_l_a, out_r_a}, 32'h7FFF_7FFF);

        // DC blocker step response
        do_reset(3);
        for (int k = 0; k < 262; k++) drive(1'b0, 16'h0000, 16'h0000);
        check_eq("dc_unmuted", {30'd0, state_b}, 32'd2);
        drive(1'b0, 16'h1000, 16'h0000);
        drive(1'b0, 16'h1000, 16'h0000);
        check_eq("dc_first", {out_l_b, out_r_b}, 32'h9000_8000);
        for (int k = 0; k < 200; k++) drive(1'b0, 16'h1000, 16'h0000);
        check_eq("dc_settle", {31'd0, (out_l_b >= 16'h8000) && (out_l_b <= 16'h8010)}, 32'd1);
        check_eq("dc_right", {16'd0, out_r_b}, 32'h0000_8000);
        check_eq("dc_bypass", {16'd0, out_l_a}, 32'h0000_9000);

        // ce gating mid-ramp
        do_reset(4);
        for (int k = 0; k < 94; k++) drive(1'b0, 16'h4000, 16'h4000);
        check_eq("gate_pre_gain", {23'd0, gain_a}, 32'd90);
        @(negedge clk_sys);
        ce = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk_sys);
            check_eq("gate_valid", {31'd0, valid_a | valid_b}, 32'd0);
            check_eq("gate_gain", {23'd0, gain_a}, 32'(m_gain));
            check_eq("gate_out", {out_l_a, out_r_a}, last_exp_a);
        end
        drive(1'b0, 16'h4000, 16'h4000);
        check_eq("gate_resume", {23'd0, gain_a}, 32'd91);
        for (int k = 0; k < 9; k++) drive(1'b0, 16'h4000, 16'h4000);
        check_eq("pre_mute_gain", {23'd0, gain_a}, 32'd100);

        // mute mid-ramp
        drive(1'b1, 16'h4000, 16'h4000);
        check_eq("mute_no_step", {23'd0, gain_a}, 32'd100);
        check_eq("mute_state", {30'd0, state_a}, 32'd3);
        check_eq("mute_flag", {31'd0, muted_a}, 32'd0);
        for (int k = 1; k <= 100; k++) begin
            drive(1'b1, 16'h4000, 16'h4000);
            if (k == 1 || k == 50 || k == 100) check_eq("down_gain", {23'd0, gain_a}, 32'(100 - k));
        end
        check_eq("down_state", {30'd0, state_a}, 32'd0);
        check_eq("down_muted", {31'd0, muted_a}, 32'd1);
        drive(1'b1, 16'h4000, 16'h4000);
        check_eq("down_out", {out_l_a, out_r_a}, 32'h8000_8000);

        @(negedge clk_sys);
        ce = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);
        check_eq("final_drain", 32'(exp_q_a.size() + exp_q_b.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
